// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants, format enum and opcode-to-format decode.
// Used by the instruction encoder and its optional immediate range checker.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_ILL
    } fmt_e;

    // Stage-1 payload: everything the packer needs one cycle later.
    typedef struct packed {
        fmt_e        fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } s1_t;

    function automatic fmt_e fmt_of(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_R:              f = FMT_R;
            OP_IMM, OP_LOAD:   f = FMT_I;
            OP_STORE:          f = FMT_S;
            OP_BRANCH:         f = FMT_B;
            OP_JAL:            f = FMT_J;
            OP_LUI, OP_AUIPC:  f = FMT_U;
            default:           f = FMT_ILL;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Request/response bus of the instruction encoder; master = requester/consumer,
// slave = encoder. Both directions use valid/ready.
interface inst_encoder_if #(
    parameter int ERR_CNT_W = 16
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [6:0]           in_opcode;
    logic [4:0]           in_rd;
    logic [4:0]           in_rs1;
    logic [4:0]           in_rs2;
    logic [2:0]           in_funct3;
    logic [6:0]           in_funct7;
    logic [31:0]          in_imm;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_instr;
    logic [1:0]           out_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        output out_ready,
        input  in_ready, out_valid, out_instr, out_err, err_count
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
        input  out_ready,
        output in_ready, out_valid, out_instr, out_err, err_count
    );
endinterface

// File: rtl/inst_encoder_range_chk.sv
// Immediate representability checker: flags immediates that the selected
// format cannot encode exactly. Purely combinational, no backpressure.
module inst_range_chk
    import riscv_pkg::*;
(
    input  fmt_e        i_fmt,
    input  logic [31:0] i_imm,
    output logic        o_violation
);
    logic w_i_ok;
    logic w_b_ok;
    logic w_j_ok;
    logic w_u_ok;

    // Sign-extension holds when all upper bits are identical.
    assign w_i_ok = (&i_imm[31:11]) || !(|i_imm[31:11]);
    assign w_b_ok = !i_imm[0] && ((&i_imm[31:12]) || !(|i_imm[31:12]));
    assign w_j_ok = !i_imm[0] && ((&i_imm[31:20]) || !(|i_imm[31:20]));
    assign w_u_ok = !(|i_imm[11:0]);

    always_comb begin
        o_violation = 1'b0;
        case (i_fmt)
            FMT_I, FMT_S: o_violation = !w_i_ok;
            FMT_B:        o_violation = !w_b_ok;
            FMT_J:        o_violation = !w_j_ok;
            FMT_U:        o_violation = !w_u_ok;
            default:      o_violation = 1'b0;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder; range check present when INST_ENC_RANGE_CHECK_EN is defined.
// Latency 2 cycles (decode/register stage, pack stage), one word per cycle.
// Backpressure: out_ready low holds both stages; in_ready drops only when both are full.
module inst_encoder
    import riscv_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    inst_encoder_if.slave  bus
);
    fmt_e w_in_fmt;
    logic w_range_err;
    logic w_s1_adv;
    logic w_s2_adv;
    s1_t  w_s1_nxt;
    logic [31:0] w_pack;

    logic                 r_s1_vld;
    s1_t                  r_s1;
    logic [1:0]           r_s1_err;
    logic                 r_s2_vld;
    logic [31:0]          r_out_instr;
    logic [1:0]           r_out_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    assign w_in_fmt = fmt_of(bus.in_opcode);

`ifdef INST_ENC_RANGE_CHECK_EN
    inst_range_chk u_range_chk (
        .i_fmt       (w_in_fmt),
        .i_imm       (bus.in_imm),
        .o_violation (w_range_err)
    );
`else
    assign w_range_err = 1'b0;
`endif

    // A stage may load when it is empty or its contents move on this cycle.
    assign w_s2_adv     = !r_s2_vld || bus.out_ready;
    assign w_s1_adv     = !r_s1_vld || w_s2_adv;
    assign bus.in_ready = w_s1_adv;

    always_comb begin
        w_s1_nxt.fmt    = w_in_fmt;
        w_s1_nxt.opcode = bus.in_opcode;
        w_s1_nxt.rd     = bus.in_rd;
        w_s1_nxt.rs1    = bus.in_rs1;
        w_s1_nxt.rs2    = bus.in_rs2;
        w_s1_nxt.funct3 = bus.in_funct3;
        w_s1_nxt.funct7 = bus.in_funct7;
        w_s1_nxt.imm    = bus.in_imm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1     <= '0;
            r_s1_err <= '0;
        end else if (w_s1_adv) begin
            r_s1_vld <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1     <= w_s1_nxt;
                r_s1_err <= {w_range_err, (w_in_fmt == FMT_ILL)};
            end
        end
    end

    always_comb begin
        w_pack = NOP;
        case (r_s1.fmt)
            FMT_R: w_pack = {r_s1.funct7, r_s1.rs2, r_s1.rs1, r_s1.funct3, r_s1.rd, r_s1.opcode};
            FMT_I: w_pack = {r_s1.imm[11:0], r_s1.rs1, r_s1.funct3, r_s1.rd, r_s1.opcode};
            FMT_S: w_pack = {r_s1.imm[11:5], r_s1.rs2, r_s1.rs1, r_s1.funct3,
                             r_s1.imm[4:0], r_s1.opcode};
            FMT_B: w_pack = {r_s1.imm[12], r_s1.imm[10:5], r_s1.rs2, r_s1.rs1, r_s1.funct3,
                             r_s1.imm[4:1], r_s1.imm[11], r_s1.opcode};
            FMT_J: w_pack = {r_s1.imm[20], r_s1.imm[10:1], r_s1.imm[11], r_s1.imm[19:12],
                             r_s1.rd, r_s1.opcode};
            FMT_U: w_pack = {r_s1.imm[31:12], r_s1.rd, r_s1.opcode};
            default: w_pack = NOP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld    <= 1'b0;
            r_out_instr <= '0;
            r_out_err   <= '0;
        end else if (w_s2_adv) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_out_instr <= w_pack;
                r_out_err   <= r_s1_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (r_s2_vld && bus.out_ready && (|r_out_err) && !(&r_err_cnt)) begin
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
    end

    assign bus.out_valid = r_s2_vld;
    assign bus.out_instr = r_out_instr;
    assign bus.out_err   = r_out_err;
    assign bus.err_count = r_err_cnt;

endmodule
